rr_mux8_arbiter: RTL and testbench
==================================

# rr_mux8_arbiter

Round-robin arbiter that shares a single 8:1 bit-select path between eight requesters. It produces the 3-bit select for the 8:1 mux and a registered copy of the selected data bit. Each grant is held until the owner drops its request or a hold limit expires. The block sits in front of the `mux8` datapath and makes its select lines the output of a sequenced, fair scheduler instead of a static input.

## Interface
- `MAX_HOLD`, default 16: maximum number of consecutive cycles one requester may keep the grant while another request is pending. Legal range is 1..255.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `req`  input  8: request lines; `req[k]` high means requester k wants the path.
- `din`  input  8: data bits; `din[k]` is requester k's bit, the same role as mux inputs `i0..i7`.
- `gnt`  output  8: one-hot grant; all zero when idle.
- `sel`  output  3: encoded index of the current or most recent grantee; drives the mux select.
- `busy`  output  1: high while a grant is active.
- `dout`  output  1: registered `din[sel]`, valid while `busy`.

## Operation
- **States:**
  - IDLE: `gnt` is 0.
  - GRANT: exactly one `gnt` bit is high and `busy` is 1.
- **Reset values:** `gnt` = 0, `busy` = 0, `sel` = 3'd7, `dout` = 0, hold counter = 0, round-robin pointer `last` = 7. The pointer value of 7 makes requester 0 highest priority after reset.
- **Arbitration function:** the first index k with `req[k]` = 1, searching `last+1`, `last+2`, … mod 8, wrapping 7→0.
- **IDLE:**
  - If `req` ≠ 0 at an edge, go to GRANT with the winner k.
  - On that transition: `gnt` = onehot(k), `sel` = k, `last` = k, counter = 1.
  - If `req` = 0, stay in IDLE. `sel` keeps its value.
- **GRANT, owner k:**
  - **Release:** `req[k]` = 0 at an edge. Re-arbitrate over `req` at that same edge. If any request is pending, grant the winner directly (back-to-back, no idle cycle). Otherwise go to IDLE.
  - **Timeout:** counter = `MAX_HOLD` and `req` has a bit set other than k. Re-arbitrate with `req[k]` masked. The winner takes the grant, which will be a different requester. Counter resets to 1.
  - **Timeout with no competitor:** counter = `MAX_HOLD` and no other request. Keep the grant; the counter saturates at `MAX_HOLD`.
  - **Otherwise:** keep the grant and increment the counter.
- **Simultaneous release and timeout:** treat as a release. The masking result is identical, because `req[k]` is already 0.
- **`dout`:** every edge, `dout` ← `din[sel_next]` when the next state is GRANT, else 0. `dout` therefore always corresponds to the `gnt` visible in the same cycle.
- **Counter width:** 8 bits, saturating. It never wraps.
- **Reset during GRANT:** all outputs return to their reset values immediately (asynchronously). The first grant after reset uses `last` = 7.

## Timing
- **Grant latency:** `req` sampled high at edge N in IDLE → `gnt`, `sel`, `busy` high after edge N. The first valid `dout` is visible in the same cycle.
- **Back-to-back handover:** zero idle cycles; `gnt` changes one-hot bit in a single edge.
- **Release latency:** owner drops `req` before edge N → `gnt` deasserted or moved after edge N.
- **Output glitches:** `gnt` is never zero-then-nonzero within a handover. `gnt` and `sel` are always consistent (`gnt` = onehot(`sel`) when `busy`).
- **Maximum wait:** with all 8 requesting continuously, any requester is granted within 7 × `MAX_HOLD` cycles of first assertion.
- **Registered outputs:** no combinational path from `req` or `din` to any output.

## Test plan
- **Reset and single request:** after reset, set `req` = 8'h00 for 3 cycles, then 8'b0010_0000.
  - After reset: `gnt` = 0, `sel` = 7, `busy` = 0, `dout` = 0.
  - One edge after the request: `gnt` = 8'h20, `sel` = 5, `busy` = 1.
- **Round-robin order:** `req` = 8'hFF continuously, each owner drops `req` for one cycle after 2 cycles of ownership, `MAX_HOLD` = 16.
  - Required grant order: 0,1,2,…,7,0.
  - No idle cycles between grants.
- **Timeout:** `MAX_HOLD` = 4, `req` = 8'b0000_0011 held constant.
  - `gnt` = 8'h01 for exactly 4 cycles, then 8'h02 for 4 cycles, then 8'h01, repeating.
- **No competitor:** `MAX_HOLD` = 4, `req` = 8'h08 for 20 cycles.
  - `gnt` = 8'h08 throughout.
  - Counter saturates at 4.
  - Dropping `req` → `gnt` = 0 and `busy` = 0 one edge later.
- **Data path:** grant requester 6, drive `din[6]` with the pattern 1,0,1,1 and `din[5]` = 1 constant.
  - `dout` follows `din[6]` with 1-cycle latency.
  - `din[5]` has no effect on `dout`.
- **Reset mid-grant:** assert `rst_n` low for half a cycle while `gnt` = 8'h10.
  - Outputs drop immediately to their reset values.
  - After release with `req` = 8'h90, the first grant goes to requester 4 (pointer reset to 7, search 0→4).

Source files
------------

// File: rtl/rr_mux8_arbiter_if.sv
// Handshake bundle between eight requesters and the round-robin mux8 arbiter.
// The master drives requests and data bits; the slave (arbiter) returns grant, select and data.
interface rr_mux8_arbiter_if;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       dout;

    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  busy,
        input  dout
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output busy,
        output dout
    );
endinterface

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 bit mux, with a hold limit
// and a registered copy of the selected data bit. All outputs are registered.
module rr_mux8_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_mux8_arbiter_if.slave  arb
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state_reg;
    logic [7:0]  gnt_reg;
    logic [2:0]  last_reg;     // doubles as the round-robin pointer and the sel output
    logic        busy_reg;
    logic        dout_reg;
    logic [7:0]  cnt_reg;

    logic [7:0]  req_eff;
    logic [7:0]  rot;
    logic [2:0]  offset;
    logic [2:0]  win_idx;
    logic        any_req;
    logic        owner_req;
    logic        hold_expired;

    // Masking the owner is harmless on release (its bit is already low) and
    // required on timeout, so one arbitration serves every re-grant case.
    assign req_eff = arb.req & ~gnt_reg;

    // rot[0] is the request just after the pointer, rot[7] is the pointer itself.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot[gi] = req_eff[last_reg + 3'(gi + 1)];
        end
    endgenerate

    always_comb begin
        offset = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                offset = 3'(i);
            end
        end
    end

    assign win_idx      = last_reg + offset + 3'd1;
    assign any_req      = |req_eff;
    assign owner_req    = |(arb.req & gnt_reg);
    assign hold_expired = (cnt_reg >= HOLD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= 8'h00;
            last_reg  <= 3'd7;
            busy_reg  <= 1'b0;
            dout_reg  <= 1'b0;
            cnt_reg   <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_reg <= GRANT;
                        gnt_reg   <= 8'b1 << win_idx;
                        last_reg  <= win_idx;
                        busy_reg  <= 1'b1;
                        dout_reg  <= arb.din[win_idx];
                        cnt_reg   <= 8'd1;
                    end else begin
                        dout_reg  <= 1'b0;
                    end
                end

                GRANT: begin
                    if (!owner_req && !any_req) begin
                        state_reg <= IDLE;
                        gnt_reg   <= 8'h00;
                        busy_reg  <= 1'b0;
                        dout_reg  <= 1'b0;
                        cnt_reg   <= 8'd0;
                    end else if (!owner_req || (hold_expired && any_req)) begin
                        // Back-to-back handover: the one-hot bit moves in a single edge.
                        gnt_reg   <= 8'b1 << win_idx;
                        last_reg  <= win_idx;
                        dout_reg  <= arb.din[win_idx];
                        cnt_reg   <= 8'd1;
                    end else begin
                        dout_reg  <= arb.din[last_reg];
                        if (!hold_expired) begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign arb.gnt  = gnt_reg;
    assign arb.sel  = last_reg;
    assign arb.busy = busy_reg;
    assign arb.dout = dout_reg;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for round-robin order, hold timeout, saturation and async reset.
module tb_rr_mux8_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_mux8_arbiter_if bus_a ();
    rr_mux8_arbiter_if bus_b ();

    rr_mux8_arbiter #(.MAX_HOLD(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus_a.slave)
    );

    rr_mux8_arbiter #(.MAX_HOLD(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // gnt must always be onehot(sel) while busy, and zero when idle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_a.busy) begin
                check("a_onehot", {24'd0, bus_a.gnt}, 32'd1 << bus_a.sel);
            end else begin
                check("a_idle_gnt", {24'd0, bus_a.gnt}, 32'd0);
            end
        end
    end

    typedef struct {
        logic [7:0] req;
        logic [7:0] din;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       dout;
    } vec_t;

    vec_t vecs [19];

    initial begin
        int  owner_cnt;
        int  held;
        bit  done;
        logic [7:0] prev_gnt;
        logic [7:0] exp_gnt;

        // req, din, expected gnt, sel, busy, dout -- one edge after the inputs are applied
        vecs[0]  = '{8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[1]  = '{8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[2]  = '{8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
        vecs[3]  = '{8'h20, 8'h00, 8'h20, 3'd5, 1'b1, 1'b0};
        vecs[4]  = '{8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1};
        vecs[5]  = '{8'h00, 8'hFF, 8'h00, 3'd5, 1'b0, 1'b0};
        vecs[6]  = '{8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
        vecs[7]  = '{8'h01, 8'h80, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[8]  = '{8'h03, 8'h02, 8'h01, 3'd0, 1'b1, 1'b0};
        vecs[9]  = '{8'h02, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1};
        vecs[10] = '{8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0};
        vecs[11] = '{8'hFF, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
        vecs[12] = '{8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        vecs[13] = '{8'h40, 8'h20, 8'h40, 3'd6, 1'b1, 1'b0};
        vecs[14] = '{8'h40, 8'h60, 8'h40, 3'd6, 1'b1, 1'b1};
        vecs[15] = '{8'h40, 8'h20, 8'h40, 3'd6, 1'b1, 1'b0};
        vecs[16] = '{8'h40, 8'h60, 8'h40, 3'd6, 1'b1, 1'b1};
        vecs[17] = '{8'h40, 8'h60, 8'h40, 3'd6, 1'b1, 1'b1};
        vecs[18] = '{8'h00, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0};

        bus_a.req = 8'h00;
        bus_a.din = 8'h00;
        bus_b.req = 8'h00;
        bus_b.din = 8'h00;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("rst_gnt",  {24'd0, bus_a.gnt}, 32'h00);
        check("rst_sel",  {29'd0, bus_a.sel}, 32'd7);
        check("rst_busy", {31'd0, bus_a.busy}, 32'd0);
        check("rst_dout", {31'd0, bus_a.dout}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            bus_a.req = vecs[i].req;
            bus_a.din = vecs[i].din;
            @(negedge clk);
            check($sformatf("v%0d_gnt", i),  {24'd0, bus_a.gnt},  {24'd0, vecs[i].gnt});
            check($sformatf("v%0d_sel", i),  {29'd0, bus_a.sel},  {29'd0, vecs[i].sel});
            check($sformatf("v%0d_busy", i), {31'd0, bus_a.busy}, {31'd0, vecs[i].busy});
            check($sformatf("v%0d_dout", i), {31'd0, bus_a.dout}, {31'd0, vecs[i].dout});
        end

        // Round robin: all requesting, each owner drops for one cycle after two cycles of ownership
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        bus_a.req = 8'hFF;
        owner_cnt = 0;
        held      = 0;
        done      = 1'b0;
        prev_gnt  = 8'h00;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            check("rr_busy", {31'd0, bus_a.busy}, 32'd1);
            if (bus_a.gnt != prev_gnt) begin
                check($sformatf("rr_owner%0d", owner_cnt), {29'd0, bus_a.sel}, 32'(owner_cnt % 8));
                owner_cnt++;
                held     = 1;
                prev_gnt = bus_a.gnt;
                if (owner_cnt == 9) done = 1'b1;
            end else begin
                held++;
            end
            bus_a.req = (held == 2) ? (8'hFF & ~bus_a.gnt) : 8'hFF;
        end
        if (!done) check("rr_budget", 32'(owner_cnt), 32'd9);
        bus_a.req = 8'h00;
        @(negedge clk);

        // Timeout with MAX_HOLD = 4 and two constant requesters
        bus_b.req = 8'h03;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_gnt = (((c / 4) % 2) == 0) ? 8'h01 : 8'h02;
            check($sformatf("to_c%0d", c), {24'd0, bus_b.gnt}, {24'd0, exp_gnt});
        end
        bus_b.req = 8'h00;
        @(negedge clk);
        check("to_idle", {24'd0, bus_b.gnt}, 32'h00);

        // No competitor: grant held, counter saturates
        bus_b.req = 8'h08;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_b.gnt !== 8'h08 || c == 19) begin
                check($sformatf("nc_c%0d", c), {24'd0, bus_b.gnt}, 32'h08);
            end
        end
        check("nc_cnt_sat", {24'd0, dut_b.cnt_reg}, 32'd4);
        bus_b.req = 8'h00;
        @(negedge clk);
        check("nc_rel_gnt",  {24'd0, bus_b.gnt},  32'h00);
        check("nc_rel_busy", {31'd0, bus_b.busy}, 32'd0);

        // Asynchronous reset in the middle of a grant
        bus_a.req = 8'h10;
        @(negedge clk);
        check("mr_pre_gnt", {24'd0, bus_a.gnt}, 32'h10);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mr_gnt",  {24'd0, bus_a.gnt},  32'h00);
        check("mr_sel",  {29'd0, bus_a.sel},  32'd7);
        check("mr_busy", {31'd0, bus_a.busy}, 32'd0);
        check("mr_dout", {31'd0, bus_a.dout}, 32'd0);
        bus_a.req = 8'h90;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_post_gnt", {24'd0, bus_a.gnt}, 32'h10);
        check("mr_post_sel", {29'd0, bus_a.sel}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
